regfile_2r1w: RTL and testbench

REGFILE_2R1W -- requirements
Module: regfile_2r1w

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_cell.sv | 16 +
 rtl/regfile_2r1w.sv | 56 +++++
 tb/tb_regfile_2r1w.sv | 119 +++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and constants for the 2-read/1-write register file
package regfile_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF = 5;
    localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_cell.sv
// regfile_cell: WIDTH-bit enabled storage register with asynchronous active-low clear
module regfile_cell
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (we) q <= d;
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with two registered read ports, one write port and same-edge bypass
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW = AW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] D,
    input  logic             RE,
    input  logic [AW-1:0]    RA1,
    input  logic [AW-1:0]    RA2,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic             QV
);
    localparam int NSLOT = 2 ** AW;
    logic [WIDTH-1:0] regs [NSLOT];
    logic [NSLOT-1:0] wr_en;
    logic [WIDTH-1:0] rd1, rd2;
    // Register 0 and out-of-range slots are hard zeros that never accept writes
    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        if (i == ZERO_REG || i >= NREG) begin : g_zero
            assign wr_en[i] = 1'b0;
            assign regs[i] = '0;
        end else begin : g_reg
            assign wr_en[i] = EN && WA == AW'(i);
            regfile_cell #(.WIDTH(WIDTH)) u_cell (
                .clk  (clk),
                .rst_n(rst_n),
                .we   (wr_en[i]),
                .d    (D),
                .q    (regs[i])
            );
        end
    end
    // A write landing on the same edge as a read of that slot forwards D
    assign rd1 = wr_en[RA1] ? D : regs[RA1];
    assign rd2 = wr_en[RA2] ? D : regs[RA2];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            Q1 <= '0;
            Q2 <= '0;
            QV <= 1'b0;
        end else begin
            QV <= RE;
            if (RE) begin
                Q1 <= rd1;
                Q2 <= rd2;
            end
        end
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed and randomized checks of regfile_2r1w against a behavioural model
module tb_regfile_2r1w;
    localparam int NREG = 32;
    logic        clk, rst_n, EN, RE;
    logic [4:0]  WA, RA1, RA2;
    logic [31:0] D, Q1, Q2;
    logic        QV;
    logic [31:0] mem [NREG];
    logic [31:0] m_q1, m_q2;
    logic        m_qv;
    int          n_chk = 0, n_fail = 0;

    regfile_2r1w dut (
        .clk(clk), .rst_n(rst_n), .EN(EN), .WA(WA), .D(D), .RE(RE),
        .RA1(RA1), .RA2(RA2), .Q1(Q1), .Q2(Q2), .QV(QV)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd(input logic [4:0] a);
        return (int'(a) < NREG) ? mem[a] : 32'h0;
    endfunction

    // Model: writes take effect first, so a same-edge read naturally sees the new value
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            foreach (mem[i]) mem[i] = '0;
            m_q1 = '0;
            m_q2 = '0;
            m_qv = 1'b0;
        end else begin
            if (EN && WA != 0 && int'(WA) < NREG) mem[WA] = D;
            if (RE) begin
                m_q1 = rd(RA1);
                m_q2 = rd(RA2);
            end
            m_qv = RE;
        end

    always @(negedge clk) begin
        chk("model_q1", Q1, m_q1);
        chk("model_q2", Q2, m_q2);
        chk("model_qv", {31'b0, QV}, {31'b0, m_qv});
    end

    task automatic cyc(input logic en, input logic [4:0] wa, input logic [31:0] d,
                       input logic re, input logic [4:0] ra1, input logic [4:0] ra2);
        EN = en; WA = wa; D = d; RE = re; RA1 = ra1; RA2 = ra2;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        EN = 0; WA = 0; D = 0; RE = 0; RA1 = 0; RA2 = 0;
        repeat (2) @(negedge clk);
        chk("rst_q1", Q1, 32'h0);
        chk("rst_qv", {31'b0, QV}, 32'h0);
        rst_n = 1'b1;
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd31);
        chk("first_q1", Q1, 32'h0);
        chk("first_q2", Q2, 32'h0);
        chk("first_qv", {31'b0, QV}, 32'h1);
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        chk("idle_qv", {31'b0, QV}, 32'h0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0);
        chk("wr5_q1", Q1, 32'hDEADBEEF);
        chk("wr5_qv", {31'b0, QV}, 32'h1);
        cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
        chk("r0_q1", Q1, 32'h0);
        cyc(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0);
        cyc(1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 5'd7);
        chk("byp_q1", Q1, 32'h22);
        chk("byp_q2", Q2, 32'h22);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd7);
        chk("pulse_qv", {31'b0, QV}, 32'h1);
        chk("pulse_q1", Q1, 32'hDEADBEEF);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'($urandom), 5'($urandom));
            chk("hold_qv", {31'b0, QV}, 32'h0);
            chk("hold_q1", Q1, 32'hDEADBEEF);
            chk("hold_q2", Q2, 32'h22);
        end
        for (int k = 0; k < 2000; k++) begin
            logic [4:0] wa;
            wa = 5'($urandom);
            cyc(1'($urandom), wa, $urandom, 1'($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
                ($urandom_range(0, 3) == 0) ? wa : 5'($urandom));
        end
        cyc(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 5'd5);
        chk("pre_rst_qv", {31'b0, QV}, 32'h1);
        chk("pre_rst_q1", Q1, 32'hA5A5A5A5);
        EN = 1'b0; RE = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_qv", {31'b0, QV}, 32'h0);
        chk("async_q1", Q1, 32'h0);
        chk("async_q2", Q2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd5);
        chk("post_rst_q1", Q1, 32'h0);
        chk("post_rst_q2", Q2, 32'h0);
        chk("post_rst_qv", {31'b0, QV}, 32'h1);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
